// File: rtl/ps2_keyboard_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_controller
// Purpose  : PS/2 device-to-host receiver with parity/framing checks, a
//            scancode FIFO, 8042-style data/status ports and a level IRQ1.
// Options  : define PS2_GLITCH_FILTER_EN to add an 8-cycle stability filter
//            on the synchronised PS2_CLK/PS2_DAT lines.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard_controller #(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [15:0] DATA_PORT   = 16'h0060,
  parameter logic [15:0] STATUS_PORT = 16'h0064
) (
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic        io_rd,
  input  logic [15:0] io_port,
  output logic [7:0]  io_rdata,
  output logic        io_rvalid,
  output logic        irq1
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_TCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TCNT_W-1:0] c_TOUT = c_TCNT_W'(TIMEOUT_CYC);
  localparam logic [c_CNT_W-1:0]  c_FULL = c_CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DATA   = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;
  localparam logic [1:0] c_STOP   = 2'd3;

  logic       r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_prev;
  logic [1:0] w_sync, w_filt;
  logic       w_clk, w_dat, w_fall;

  // Two-flop synchronisers for both asynchronous pins; idle level is high.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1; r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1; r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk; r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat; r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_sync = {r_dat_s2, r_clk_s2};

`ifdef PS2_GLITCH_FILTER_EN
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic [2:0] r_cnt;
    logic       r_out;
    // Output follows the input only once it has held a new value for 8 cycles.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= 3'd0;
        r_out <= 1'b1;
      end else if (w_sync[g] == r_out) begin
        r_cnt <= 3'd0;
      end else if (r_cnt == 3'd7) begin
        r_cnt <= 3'd0;
        r_out <= w_sync[g];
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
    assign w_filt[g] = r_out;
  end
`else
  assign w_filt = w_sync;
`endif

  assign w_clk  = w_filt[0];
  assign w_dat  = w_filt[1];
  assign w_fall = r_clk_prev & ~w_clk;

  // Previous clock level for falling-edge detection.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) r_clk_prev <= 1'b1;
    else        r_clk_prev <= w_clk;
  end

  logic [1:0]          r_state, w_state_nxt;
  logic [2:0]          r_bitcnt;
  logic [7:0]          r_shift;
  logic                r_par;
  logic [c_TCNT_W-1:0] r_tcnt;
  logic                w_tout_hit, w_push, w_perr_set;

  assign w_tout_hit = (r_state != c_IDLE) && (r_tcnt == c_TOUT);

  // Receive FSM state register.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: advance on falling edges; a timeout aborts to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (w_tout_hit) begin
      w_state_nxt = c_IDLE;
    end else if (w_fall) begin
      case (r_state)
        c_IDLE:   if (!w_dat) w_state_nxt = c_DATA;
        c_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = c_PARITY;
        c_PARITY: w_state_nxt = c_STOP;
        default:  w_state_nxt = c_IDLE;
      endcase
    end
  end

  // FSM outputs: at the stop bit either deliver the byte or flag an error.
  always_comb begin
    w_push     = 1'b0;
    w_perr_set = 1'b0;
    if (!w_tout_hit && w_fall && (r_state == c_STOP)) begin
      if (w_dat && (^{r_shift, r_par})) w_push     = 1'b1;
      else                              w_perr_set = 1'b1;
    end
  end

  // Frame datapath: bit counter, LSB-first shift register, parity capture.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
      r_par    <= 1'b0;
    end else if (w_fall && !w_tout_hit) begin
      case (r_state)
        c_IDLE:   r_bitcnt <= 3'd0;
        c_DATA: begin
          r_shift  <= {w_dat, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        c_PARITY: r_par <= w_dat;
        default:  ;
      endcase
    end
  end

  // Mid-frame inactivity counter; held at zero while idle.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n)                                      r_tcnt <= '0;
    else if ((r_state == c_IDLE) || w_fall || w_tout_hit) r_tcnt <= '0;
    else                                             r_tcnt <= r_tcnt + 1'b1;
  end

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wptr, r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_empty, w_full, w_rd_data, w_rd_stat, w_pop, w_push_acc;
  logic               r_perr, r_tout, r_ovr, r_last_valid_unused;
  logic [7:0]         r_last;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_FULL);
  assign w_rd_data  = io_rd && (io_port == DATA_PORT);
  assign w_rd_stat  = io_rd && (io_port == STATUS_PORT);
  assign w_pop      = w_rd_data && !w_empty;
  assign w_push_acc = w_push && !w_full;

  // Storage array; contents need no reset because the count gates reads.
  always_ff @(posedge clk_cpu) begin
    if (w_push_acc) r_mem[r_wptr] <= r_shift;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop)      r_rptr <= r_rptr + 1'b1;
      case ({w_push_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky flags: a same-cycle set wins over the status-read clear.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0; r_tout <= 1'b0; r_ovr <= 1'b0;
    end else begin
      r_perr <= w_perr_set          | (r_perr & ~w_rd_stat);
      r_tout <= w_tout_hit          | (r_tout & ~w_rd_stat);
      r_ovr  <= (w_push && w_full)  | (r_ovr  & ~w_rd_stat);
    end
  end

  // I/O read response, last-data register and IRQ level.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata  <= 8'd0;
      io_rvalid <= 1'b0;
      r_last    <= 8'd0;
      irq1      <= 1'b0;
    end else begin
      io_rvalid <= w_rd_data | w_rd_stat;
      irq1      <= !w_empty;
      if (w_rd_data) begin
        io_rdata <= w_empty ? r_last : r_mem[r_rptr];
        if (w_pop) r_last <= r_mem[r_rptr];
      end else if (w_rd_stat) begin
        io_rdata <= {r_perr, r_tout, r_ovr, 4'b0000, !w_empty};
      end
    end
  end

  assign r_last_valid_unused = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keyboard_controller
// Purpose  : Directed scoreboard bench for ps2_keyboard_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_controller;

  logic        clk_cpu = 1'b0;
  logic        rst_n   = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        io_rd   = 1'b0;
  logic [15:0] io_port = 16'h0000;
  logic [7:0]  io_rdata;
  logic        io_rvalid;
  logic        irq1;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  always #5 clk_cpu = ~clk_cpu;

  ps2_keyboard_controller #(
    .FIFO_DEPTH  (8),
    .TIMEOUT_CYC (200),
    .DATA_PORT   (16'h0060),
    .STATUS_PORT (16'h0064)
  ) dut (
    .clk_cpu   (clk_cpu),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .io_rd     (io_rd),
    .io_port   (io_port),
    .io_rdata  (io_rdata),
    .io_rvalid (io_rvalid),
    .irq1      (irq1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  // Scoreboard: every read response is popped and compared here.
  always @(negedge clk_cpu) begin
    if (io_rvalid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $error("FAIL unexpected_rvalid: observed rdata %02h expected no response", io_rdata);
      end else begin
        chk(tag_q.pop_front(), io_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic wait_resp(input string tag);
    repeat (2) @(negedge clk_cpu);
    if (exp_q.size() != 0) begin
      n_total++;
      $error("FAIL %s: observed no io_rvalid expected response within 3 cycles", tag);
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic rd(input logic [15:0] p, input logic [7:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    io_rd = 1'b1; io_port = p;
    @(negedge clk_cpu);
    io_rd = 1'b0; io_port = 16'h0000;
    wait_resp(tag);
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    repeat (5) @(negedge clk_cpu);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk_cpu);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk_cpu);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stp);
    repeat (5) @(negedge clk_cpu);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge clk_cpu);
    chk("reset_rdata", io_rdata, 8'h00);
    chk("reset_rvalid", {7'd0, io_rvalid}, 8'h00);
    chk("reset_irq1", {7'd0, irq1}, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_cpu);
    rd(16'h0064, 8'h00, "status_after_reset");
    rd(16'h0060, 8'h00, "data_after_reset");

    // Valid frame 0x1C
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("irq1_after_1C", {7'd0, irq1}, 8'h01);
    rd(16'h0064, 8'h01, "status_1C");
    rd(16'h0060, 8'h1C, "data_1C");
    chk("irq1_after_pop", {7'd0, irq1}, 8'h00);
    rd(16'h0064, 8'h00, "status_empty");

    // Read of an unmapped port: no response expected
    io_rd = 1'b1; io_port = 16'h0061;
    @(negedge clk_cpu);
    io_rd = 1'b0; io_port = 16'h0000;
    repeat (3) @(negedge clk_cpu);

    // Parity error
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("irq1_perr", {7'd0, irq1}, 8'h00);
    rd(16'h0064, 8'h80, "status_perr");
    rd(16'h0064, 8'h00, "status_perr_cleared");

    // Timeout after start + 4 data bits, then a valid 0xF0
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (300) @(negedge clk_cpu);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1);
    rd(16'h0064, 8'h41, "status_tout");
    rd(16'h0060, 8'hF0, "data_F0");

    // Overflow: 9 frames into an 8-entry FIFO
    for (int k = 1; k <= 9; k++) send_frame(8'(k), odd_par(8'(k)), 1'b1);
    rd(16'h0064, 8'h21, "status_ovr");
    for (int k = 1; k <= 8; k++) rd(16'h0060, 8'(k), "data_drain");
    rd(16'h0060, 8'h08, "data_last_repeat");
    rd(16'h0064, 8'h00, "status_drained");

    // Simultaneous push (0x5A stop) and pop (0x29 queued)
    send_frame(8'h29, odd_par(8'h29), 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h5A >> i));
    send_bit(odd_par(8'h5A));
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk_cpu);
    ps2_clk = 1'b0;
    exp_q.push_back(8'h29);
    tag_q.push_back("data_push_pop");
    repeat (2) @(negedge clk_cpu);
    io_rd = 1'b1; io_port = 16'h0060;
    @(negedge clk_cpu);
    io_rd = 1'b0; io_port = 16'h0000;
    wait_resp("data_push_pop");
    repeat (5) @(negedge clk_cpu);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk_cpu);
    rd(16'h0064, 8'h01, "status_count_one");
    rd(16'h0060, 8'h5A, "data_5A");
    rd(16'h0064, 8'h00, "status_after_5A");

    // Reset mid-frame, then 0x3A
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_cpu);
    chk("midreset_irq1", {7'd0, irq1}, 8'h00);
    chk("midreset_rdata", io_rdata, 8'h00);
    rst_n = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk_cpu);
    send_frame(8'h3A, odd_par(8'h3A), 1'b1);
    rd(16'h0064, 8'h01, "status_3A");
    rd(16'h0060, 8'h3A, "data_3A");
    rd(16'h0064, 8'h00, "status_only_3A");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
